// File: rtl/id_exe_stage.sv
// ID/EX pipeline register: valid/ready handshake, optional one-entry skid buffer,
// flush-to-bubble and a saturating bubble counter. State updates on the falling edge of Clk.
module id_exe_stage #(
    parameter int unsigned CTRL_W = 35,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_DATA = 8,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [N_DATA*DATA_W-1:0] in_data,
    input  logic [3*REG_W-1:0]       in_regs,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [N_DATA*DATA_W-1:0] out_data,
    output logic [3*REG_W-1:0]       out_regs,
    output logic [CNT_W-1:0]         bubble_cnt
);
    localparam int unsigned DW = N_DATA * DATA_W;
    localparam int unsigned RW = 3 * REG_W;

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DW-1:0]     main_data;
    logic [RW-1:0]     main_regs;

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DW-1:0]     skid_data;
    logic [RW-1:0]     skid_regs;

    logic              accept;
    logic              consume;

    always_comb begin
        in_ready = 1'b0;
        if (SKID != 0) in_ready = ~skid_valid;
        else           in_ready = ~main_valid | out_ready;
    end

    assign accept  = in_valid & in_ready;
    assign consume = main_valid & out_ready;

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign out_regs  = main_regs;

    // Skid drains into main before any new beat is taken, which keeps FIFO order;
    // in_ready is low while skid is full so accept never coincides with the drain.
    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            main_regs  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            skid_regs  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (consume && skid_valid) begin
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            main_regs  <= skid_regs;
            skid_valid <= 1'b0;
        end else if (accept && (!main_valid || consume)) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
            main_regs  <= in_regs;
        end else if (accept && (SKID != 0)) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            skid_regs  <= in_regs;
        end else if (consume) begin
            main_valid <= 1'b0;
        end
    end

    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bubble_cnt <= '0;
        end else if (out_ready && !main_valid && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule
